// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative shift-add multiplier and restoring divider.
// Optional same-cycle MTHI/MTLO read forwarding when HILO_FWD_EN is defined.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             read_sel,
  output logic [WIDTH-1:0] read_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_opnd, r_a_orig;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_is_div, r_neg_q, r_neg_r, r_dbz, r_done;

  logic               w_accept, w_start_mul, w_start_div, w_signed, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic [WIDTH-1:0]   w_div_diff, w_quo, w_rem;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept    = op_valid && (r_state == S_IDLE);
  assign w_start_mul = w_accept && (op_code == 3'd1 || op_code == 3'd2);
  assign w_start_div = w_accept && (op_code == 3'd3 || op_code == 3'd4);
  assign w_signed    = (op_code == 3'd1) || (op_code == 3'd3);
  assign w_abs_a     = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_abs_b     = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_next = S_MUL;
        else if (w_start_div) w_next = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_a_orig <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_accept && op_code == 3'd5) r_hi <= src_a;
          if (w_accept && op_code == 3'd6) r_lo <= src_a;
          if (w_start_mul || w_start_div) begin
            r_cnt    <= '0;
            r_is_div <= w_start_div;
            r_a_orig <= src_a;
            r_dbz    <= (src_b == '0);
            r_neg_q  <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_r  <= w_signed && src_a[WIDTH-1];
            r_opnd   <= w_start_div ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_start_div ? w_abs_a : w_abs_b)};
          end
        end
        S_MUL: begin
          r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_div_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
          end else if (r_dbz) begin
            r_lo <= '1;
            r_hi <= r_a_orig;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

`ifdef HILO_FWD_EN
  always_comb begin
    read_data = read_sel ? r_hi : r_lo;
    if (w_accept && ((op_code == 3'd5 && read_sel) || (op_code == 3'd6 && !read_sel)))
      read_data = src_a;
  end
`else
  assign read_data = read_sel ? r_hi : r_lo;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        read_sel;
  logic [31:0] read_data;
  logic        busy, done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .read_sel(read_sel),
    .read_data(read_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned up;
    hi = m_hi;
    lo = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      3'd1: begin q = sa * sb; {hi, lo} = q; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      3'd3, 3'd4: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else if (code == 3'd3) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endtask

  task automatic rd(input logic sel, output logic [31:0] v);
    read_sel = sel;
    #1;
    v = read_data;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    rd(1'b1, v); check({tag, "_hi"}, v, m_hi);
    rd(1'b0, v); check({tag, "_lo"}, v, m_lo);
  endtask

  task automatic short_op(input logic [2:0] code, input logic [31:0] a);
    @(negedge clk);
    op_valid = 1'b1; op_code = code; src_a = a; src_b = $urandom;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    model(code, a, 32'd0, m_hi, m_lo);
    check("short_busy", {31'b0, busy}, 32'd0);
    check("short_done", {31'b0, done}, 32'd0);
    check_regs("short");
  endtask

  task automatic long_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input bit poke_mthi);
    logic [31:0] v, e_hi, e_lo;
    int unsigned cyc;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    model(code, a, b, e_hi, e_lo);
    rd(1'b1, v); check("busy_read_hi", v, m_hi);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (poke_mthi && cyc == 5) begin
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd5; src_a = 32'h1234_5678;
        @(posedge clk); #1;
        op_valid = 1'b0; op_code = 3'd0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
      if (!busy || cyc == 1) check("done_early", {31'b0, done}, {31'b0, !busy});
    end
    check("busy_cycles", cyc, 32'd33);
    m_hi = e_hi; m_lo = e_lo;
    check_regs("long");
  endtask

  initial begin
    logic [31:0] v;
    logic [2:0]  c;
    logic [31:0] a, b;
    rst = 1'b0; op_valid = 1'b0; op_code = 3'd0; src_a = '0; src_b = '0; read_sel = 1'b0;
    m_hi = '0; m_lo = '0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check_regs("rst");
    @(negedge clk); rst = 1'b1;

    long_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("multu_hi_const", m_hi, 32'h0000_0001);
    @(posedge clk); #1;
    check("done_pulse_len", {31'b0, done}, 32'd0);
    long_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    long_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    long_op(3'd4, 32'd5, 32'd0, 1'b0);
    long_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    long_op(3'd3, 32'hFFFF_FFF9, 32'd0, 1'b0);
    long_op(3'd2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);

    // Reset mid-divide
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd3; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    m_hi = '0; m_lo = '0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check_regs("abort");
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) check("abort_done", {31'b0, done}, 32'd0);
    end
    check_regs("abort_after");

    // Same-cycle MTLO read
    short_op(3'd5, 32'h0BAD_F00D);
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd6; src_a = 32'hA5A5_A5A5; read_sel = 1'b0;
    #1;
`ifdef HILO_FWD_EN
    check("fwd_same_cycle", read_data, 32'hA5A5_A5A5);
`else
    check("fwd_same_cycle", read_data, m_lo);
`endif
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    m_lo = 32'hA5A5_A5A5;
    check("fwd_next_cycle", read_data, 32'hA5A5_A5A5);

    // NOP and reserved codes change nothing
    short_op(3'd0, 32'h1111_1111);
    short_op(3'd7, 32'h2222_2222);

    for (int i = 0; i < 30; i++) begin
      c = 3'($urandom_range(1, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      if (c >= 3'd5) short_op(c, a);
      else           long_op(c, a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
